// File: rtl/msg_scroller.sv
// rtl/msg_scroller.sv - scrolling six-digit message window over a loadable character buffer
//
// Purpose : holds a MAX_LEN-entry buffer of CHAR_W-bit character codes and
//           presents a NUM_DIGITS-wide window of it, rotating one position per
//           tick while running. Start/stop/clear control, write port open only
//           while idle.
// Ports   : clk, reset (async, active-high)
//           tick                     - advance strobe from the frequency divider
//           wr_en/wr_addr/wr_data    - buffer write, accepted when wr_ready=1
//           wr_ready                 - high in IDLE only
//           msg_len                  - active length, clamped to 1..MAX_LEN on start from IDLE
//           start/stop/clear         - run control (clear > stop > start > tick)
//           dir                      - 0 scrolls left (pos+1), 1 scrolls right (pos-1)
//           pos                      - current window start index
//           running                  - high in RUN
//           disp_chars               - registered window, leftmost digit in the MSBs
// Option  : MSG_SCROLLER_BLINK_EN - ticks while paused toggle a blank-out of the display.

module msg_scroller #(
    parameter int                CHAR_W     = 3,
    parameter int                MAX_LEN    = 8,
    parameter int                NUM_DIGITS = 6,
    parameter logic [CHAR_W-1:0] BLANK      = 3'b111
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_LEN)-1:0]   wr_addr,
    input  logic [CHAR_W-1:0]            wr_data,
    output logic                         wr_ready,
    input  logic [$clog2(MAX_LEN+1)-1:0] msg_len,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         clear,
    input  logic                         dir,
    output logic [$clog2(MAX_LEN)-1:0]   pos,
    output logic                         running,
    output logic [NUM_DIGITS*CHAR_W-1:0] disp_chars
);

    localparam int POS_W  = $clog2(MAX_LEN);
    localparam int LEN_W  = $clog2(MAX_LEN+1);
    localparam int DISP_W = NUM_DIGITS * CHAR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   len_clamped;
    logic [POS_W-1:0]   len_m1;
    logic [POS_W-1:0]   pos_fwd, pos_bwd;
    logic [DISP_W-1:0]  window;
    logic [DISP_W-1:0]  disp_d;
    logic [CHAR_W-1:0]  msg_buf [MAX_LEN];
`ifdef MSG_SCROLLER_BLINK_EN
    logic               blink_q, blink_d;
`endif

    assign wr_ready = (state_q == ST_IDLE);
    assign running  = (state_q == ST_RUN);
    assign pos      = pos_q;

    // len_q is always in 1..MAX_LEN, so the last valid index fits in POS_W bits.
    assign len_m1  = POS_W'(len_q - LEN_W'(1));
    assign pos_fwd = (pos_q == len_m1) ? '0 : pos_q + 1'b1;
    assign pos_bwd = (pos_q == '0) ? len_m1 : pos_q - 1'b1;

    always_comb begin
        len_clamped = msg_len;
        if (msg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (msg_len > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // Walk the buffer from pos with wrap at len_q; short messages repeat
    // across the window because the index keeps wrapping.
    always_comb begin
        logic [POS_W-1:0] idx;
        window = '0;
        idx    = pos_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            window[(NUM_DIGITS-1-i)*CHAR_W +: CHAR_W] = msg_buf[idx];
            idx = (idx == len_m1) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
`ifdef MSG_SCROLLER_BLINK_EN
        blink_d = blink_q;
`endif
        if (clear) begin
            state_d = ST_IDLE;
            pos_d   = '0;
`ifdef MSG_SCROLLER_BLINK_EN
            blink_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pos_d = '0;
                    if (!stop && start) begin
                        len_d   = len_clamped;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (!start && tick) begin
                        pos_d = dir ? pos_bwd : pos_fwd;
                    end
                end
                ST_PAUSE: begin
                    if (!stop && start) begin
                        state_d = ST_RUN;
`ifdef MSG_SCROLLER_BLINK_EN
                        blink_d = 1'b0;
`endif
                    end
`ifdef MSG_SCROLLER_BLINK_EN
                    else if (!stop && tick) begin
                        blink_d = ~blink_q;
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    pos_d   = '0;
                end
            endcase
        end
    end

`ifdef MSG_SCROLLER_BLINK_EN
    assign disp_d = blink_q ? {NUM_DIGITS{BLANK}} : window;
`else
    assign disp_d = window;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pos_q      <= '0;
            len_q      <= LEN_W'(1);
            disp_chars <= {NUM_DIGITS{BLANK}};
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            len_q      <= len_d;
            disp_chars <= disp_d;
        end
    end

`ifdef MSG_SCROLLER_BLINK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                msg_buf[i] <= BLANK;
            end
        end else if (wr_en && wr_ready) begin
            msg_buf[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_msg_scroller.sv
// tb/tb_msg_scroller.sv - self-checking bench for msg_scroller

module tb_msg_scroller;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [2:0]  wr_data;
    logic        wr_ready;
    logic [3:0]  msg_len;
    logic        start;
    logic        stop;
    logic        clear;
    logic        dir;
    logic [2:0]  pos;
    logic        running;
    logic [17:0] disp_chars;

    int checks   = 0;
    int failures = 0;

    int          m_buf [8];
    int          m_pos;
    int          m_len;
    bit          m_blink;
    logic [17:0] sb_q [$];
    logic [17:0] exp_d;

    msg_scroller dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .msg_len    (msg_len),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .dir        (dir),
        .pos        (pos),
        .running    (running),
        .disp_chars (disp_chars)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [17:0] model_window();
        logic [17:0] w;
        w = '0;
        for (int i = 0; i < 6; i++) begin
            w[(5-i)*3 +: 3] = 3'(m_buf[(m_pos + i) % m_len]);
        end
        if (m_blink) w = 18'h3FFFF;
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_buf[i] = 7;
        m_pos   = 0;
        m_len   = 1;
        m_blink = 1'b0;
    endfunction

    function automatic void model_advance(input logic d);
        if (d == 1'b0) m_pos = (m_pos == m_len - 1) ? 0 : m_pos + 1;
        else           m_pos = (m_pos == 0) ? m_len - 1 : m_pos - 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b1; tick = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        msg_len = 0; start = 0; stop = 0; clear = 0; dir = 0;
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++; if (disp_chars !== 18'h3FFFF) begin failures++; $display("FAIL reset_disp got=%h exp=%h", disp_chars, 18'h3FFFF); end
        checks++; if (pos !== 3'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", pos); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    endtask

    task automatic test_write_start();
        for (int a = 0; a < 6; a++) begin
            wr_en = 1; wr_addr = 3'(a); wr_data = 3'(a);
            step();
            m_buf[a] = a;
        end
        wr_en = 0;
        msg_len = 4'd6; start = 1;
        step();
        start = 0; m_len = 6;
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", running); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL start_wr_ready got=%b exp=0", wr_ready); end
        sb_q.push_back(model_window());
        step();
        if (sb_q.size() == 0) begin checks++; failures++; $display("FAIL start_sb_empty"); end
        else begin
            exp_d = sb_q.pop_front();
            checks++; if (disp_chars !== exp_d) begin failures++; $display("FAIL start_disp got=%h exp=%h", disp_chars, exp_d); end
        end
        checks++; if (disp_chars !== 18'h014E5) begin failures++; $display("FAIL start_disp_const got=%h exp=%h", disp_chars, 18'h014E5); end
    endtask

    task automatic test_tick_left();
        dir = 0; tick = 1;
        step();
        tick = 0; model_advance(1'b0);
        checks++; if (pos !== 3'd1) begin failures++; $display("FAIL tick_left_pos got=%0d exp=1", pos); end
        sb_q.push_back(model_window());
        step();
        if (sb_q.size() == 0) begin checks++; failures++; $display("FAIL tick_left_sb_empty"); end
        else begin
            exp_d = sb_q.pop_front();
            checks++; if (disp_chars !== exp_d) begin failures++; $display("FAIL tick_left_disp got=%h exp=%h", disp_chars, exp_d); end
        end
        checks++; if (disp_chars !== 18'h0A728) begin failures++; $display("FAIL tick_left_const got=%h exp=%h", disp_chars, 18'h0A728); end
    endtask

    // Six left ticks (wrapping 5->0), then two right ticks (1->0->5),
    // then three left ticks (5->0->1->2).
    task automatic test_wrap();
        logic dirs [11];
        for (int k = 0; k < 11; k++) dirs[k] = (k == 6 || k == 7) ? 1'b1 : 1'b0;
        for (int k = 0; k < 11; k++) begin
            dir = dirs[k]; tick = 1;
            step();
            tick = 0; model_advance(dirs[k]);
            checks++; if (pos !== 3'(m_pos)) begin failures++; $display("FAIL wrap_pos[%0d] got=%0d exp=%0d", k, pos, m_pos); end
            sb_q.push_back(model_window());
            step();
            if (sb_q.size() == 0) begin checks++; failures++; $display("FAIL wrap_sb_empty[%0d]", k); end
            else begin
                exp_d = sb_q.pop_front();
                checks++; if (disp_chars !== exp_d) begin failures++; $display("FAIL wrap_disp[%0d] got=%h exp=%h", k, disp_chars, exp_d); end
            end
        end
        checks++; if (pos !== 3'd2) begin failures++; $display("FAIL wrap_end_pos got=%0d exp=2", pos); end
    endtask

    task automatic test_stop_pause();
        dir = 0; stop = 1; tick = 1;
        step();
        stop = 0; tick = 0;
        checks++; if (pos !== 3'd2) begin failures++; $display("FAIL stop_pos got=%0d exp=2", pos); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_running got=%b exp=0", running); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL stop_wr_ready got=%b exp=0", wr_ready); end
        for (int k = 0; k < 3; k++) begin
            tick = 1;
            step();
            tick = 0;
`ifdef MSG_SCROLLER_BLINK_EN
            m_blink = ~m_blink;
`endif
            checks++; if (pos !== 3'd2) begin failures++; $display("FAIL pause_pos[%0d] got=%0d exp=2", k, pos); end
            sb_q.push_back(model_window());
            step();
            if (sb_q.size() == 0) begin checks++; failures++; $display("FAIL pause_sb_empty[%0d]", k); end
            else begin
                exp_d = sb_q.pop_front();
                checks++; if (disp_chars !== exp_d) begin failures++; $display("FAIL pause_disp[%0d] got=%h exp=%h", k, disp_chars, exp_d); end
            end
        end
        start = 1;
        step();
        start = 0; m_blink = 0;
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume_running got=%b exp=1", running); end
        tick = 1;
        step();
        tick = 0; model_advance(1'b0);
        checks++; if (pos !== 3'd3) begin failures++; $display("FAIL resume_pos got=%0d exp=3", pos); end
        sb_q.push_back(model_window());
        step();
        if (sb_q.size() == 0) begin checks++; failures++; $display("FAIL resume_sb_empty"); end
        else begin
            exp_d = sb_q.pop_front();
            checks++; if (disp_chars !== exp_d) begin failures++; $display("FAIL resume_disp got=%h exp=%h", disp_chars, exp_d); end
        end
    endtask

    task automatic test_write_in_run();
        wr_en = 1; wr_addr = 3'd0; wr_data = 3'd6;
        step();
        wr_en = 0;
        sb_q.push_back(model_window());
        step();
        if (sb_q.size() == 0) begin checks++; failures++; $display("FAIL run_write_sb_empty"); end
        else begin
            exp_d = sb_q.pop_front();
            checks++; if (disp_chars !== exp_d) begin failures++; $display("FAIL run_write_disp got=%h exp=%h", disp_chars, exp_d); end
        end
    endtask

    task automatic test_len_zero();
        clear = 1;
        step();
        clear = 0; m_pos = 0;
        checks++; if (pos !== 3'd0) begin failures++; $display("FAIL clear_pos got=%0d exp=0", pos); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL clear_wr_ready got=%b exp=1", wr_ready); end
        msg_len = 4'd0; start = 1;
        step();
        start = 0; m_len = 1;
        tick = 1; dir = 0;
        step();
        tick = 0; model_advance(1'b0);
        checks++; if (pos !== 3'd0) begin failures++; $display("FAIL len0_pos got=%0d exp=0", pos); end
        sb_q.push_back(model_window());
        step();
        if (sb_q.size() == 0) begin checks++; failures++; $display("FAIL len0_sb_empty"); end
        else begin
            exp_d = sb_q.pop_front();
            checks++; if (disp_chars !== exp_d) begin failures++; $display("FAIL len0_disp got=%h exp=%h", disp_chars, exp_d); end
        end
    endtask

    task automatic test_len_clamp();
        clear = 1;
        step();
        clear = 0; m_pos = 0;
        msg_len = 4'd15; start = 1;
        step();
        start = 0; m_len = 8;
        dir = 1; tick = 1;
        step();
        tick = 0; model_advance(1'b1);
        checks++; if (pos !== 3'd7) begin failures++; $display("FAIL clamp_pos got=%0d exp=7", pos); end
        sb_q.push_back(model_window());
        step();
        if (sb_q.size() == 0) begin checks++; failures++; $display("FAIL clamp_sb_empty"); end
        else begin
            exp_d = sb_q.pop_front();
            checks++; if (disp_chars !== exp_d) begin failures++; $display("FAIL clamp_disp got=%h exp=%h", disp_chars, exp_d); end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        reset = 1;
        #1;
        model_reset();
        checks++; if (disp_chars !== 18'h3FFFF) begin failures++; $display("FAIL areset_disp got=%h exp=%h", disp_chars, 18'h3FFFF); end
        checks++; if (pos !== 3'd0) begin failures++; $display("FAIL areset_pos got=%0d exp=0", pos); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL areset_running got=%b exp=0", running); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL areset_wr_ready got=%b exp=1", wr_ready); end
        step();
        reset = 0;
        msg_len = 4'd6; start = 1;
        step();
        start = 0; m_len = 6;
        sb_q.push_back(model_window());
        step();
        if (sb_q.size() == 0) begin checks++; failures++; $display("FAIL areset_sb_empty"); end
        else begin
            exp_d = sb_q.pop_front();
            checks++; if (disp_chars !== exp_d) begin failures++; $display("FAIL areset_buf_disp got=%h exp=%h", disp_chars, exp_d); end
        end
    endtask

    initial begin
        test_reset();
        test_write_start();
        test_tick_left();
        test_wrap();
        test_stop_pause();
        test_write_in_run();
        test_len_zero();
        test_len_clamp();
        test_async_reset();
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msg_scroller.md
Name: msg_scroller

Overview:
- Scrolling-message controller that sits between the 1 Hz frequency-divider tick and the six `seven_seg_display` character decoders (HEX5..HEX0).
- Holds a writable message buffer of 3-bit character codes and rotates a six-digit window across it, one position per tick.
- Replaces the hard-wired mux bank and free-running opcode counter with a loadable, start/stop controllable scroller.

Parameters:
- CHAR_W, 3, width of one character code (matches `seven_seg_display` input).
- MAX_LEN, 8, message buffer depth in characters.
- NUM_DIGITS, 6, number of display digits driven.
- BLANK, 3'b111, code the decoder renders as all segments off.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  single-cycle advance strobe from the frequency divider, synchronous to clk.
- wr_en  in  1  buffer write request.
- wr_addr  in  3  buffer index 0..MAX_LEN-1.
- wr_data  in  CHAR_W  character code to write.
- wr_ready  out  1  high when writes are accepted.
- msg_len  in  4  active message length, sampled on start.
- start  in  1  begin or resume scrolling.
- stop  in  1  freeze scrolling.
- clear  in  1  return to IDLE with pos=0.
- dir  in  1  0 = scroll left (pos+1), 1 = scroll right (pos-1).
- pos  out  3  current window start index.
- running  out  1  high in RUN state.
- disp_chars  out  NUM_DIGITS*CHAR_W  window characters; [17:15] = leftmost digit (HEX5), [2:0] = HEX0.

Behaviour:
- Decided interface: reset reset, asynchronous, active-high; clock clk.
- Reset values: every buffer entry = BLANK, pos=0, state=IDLE, len_q=1, running=0, wr_ready=1, disp_chars = all BLANK (18'h3FFFF).
- States: IDLE, RUN, PAUSE.
  - IDLE: wr_ready=1; pos held at 0; tick ignored.
  - IDLE + start: latch len_q = clamp(msg_len); go to RUN.
  - RUN: wr_ready=0; writes ignored. Each cycle with tick=1, pos advances per dir and wraps modulo len_q (left: len_q-1 -> 0; right: 0 -> len_q-1).
  - RUN + stop: go to PAUSE with pos retained; wr_ready stays 0.
  - PAUSE + start: go to RUN without relatching msg_len.
  - clear from any state: go to IDLE, pos=0. Buffer contents are kept.
- Priority on simultaneous inputs: clear > stop > start > tick. A tick in the same cycle as stop or clear does not advance pos.
- Length clamp: msg_len=0 is treated as 1; msg_len > MAX_LEN is treated as MAX_LEN.
- Window: digit i (i=0 is leftmost) = buf[(pos+i) mod len_q]. If len_q < NUM_DIGITS, the message repeats across the window.
- Write: a write with wr_en & wr_ready stores wr_data at wr_addr on that edge.
- Latency: disp_chars is registered and reflects current buf/pos one cycle later. A tick sampled at edge N gives a new pos after edge N and a new disp_chars after edge N+1. A write is visible on disp_chars 2 edges after it is sampled.
- Asserting reset mid-RUN returns immediately to reset values, including buffer contents.

Optional Feature:
- Macro: MSG_SCROLLER_BLINK_EN.
- Defined: in PAUSE, each tick toggles an internal blink bit; while blink=1, disp_chars = all BLANK. blink clears on leaving PAUSE and on reset.
- Undefined: PAUSE shows the frozen window statically and ticks have no effect.

Test Plan:
- Reset release -> disp_chars=18'h3FFFF, pos=0, wr_ready=1, running=0.
- Write codes 0,1,2,3,4,5 to addr 0..5; msg_len=6; start -> disp_chars=18'h014E5 (L,E,A,F,6,7).
- One tick in RUN, dir=0 -> pos=1; two edges after tick, disp_chars=18'h0A728 (E,A,F,6,7,L).
- Six ticks from pos=1 -> pos wraps 5 -> 0 on the 5th tick and reads 1 after the 6th. Repeat with dir=1 from pos=0 -> pos=5 after one tick.
- stop with coincident tick at pos=2 -> pos stays 2, PAUSE entered. Then start with tick on a later cycle -> pos=3. With MSG_SCROLLER_BLINK_EN, ticks in PAUSE alternate disp_chars between the window and 18'h3FFFF.
- Write during RUN to addr 0 -> buffer unchanged. msg_len=0, then start -> len_q=1 and all digits equal buf[0]. Assert reset mid-RUN -> outputs return to reset values without waiting for clk.
